// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the streaming convolution core.
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_EMIT = 2'd2
  } state_e;

  // Taps in one KxK kernel.
  function automatic int unsigned num_taps(input int unsigned k);
    return k * k;
  endfunction

  // Per-channel stride in weight memory: K*K weights followed by one bias.
  function automatic int unsigned ch_stride(input int unsigned k);
    return k * k + 1;
  endfunction

  // Address/index width for n entries, never narrower than one bit.
  function automatic int unsigned addr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_line_window.sv
// K-1 raster line buffers feeding a KxK sliding pixel window.
module conv_line_window
  import conv_pkg::*;
#(
  parameter int unsigned IMG_W      = 28,
  parameter int unsigned K          = 5,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en_i,
  input  logic [DATA_WIDTH-1:0]          pixel_i,
  output logic [K*K*DATA_WIDTH-1:0]      win_o
);

  localparam int unsigned LB_LEN = (K - 1) * IMG_W;
  localparam int unsigned TAPS   = num_taps(K);

  // lb_q[i] holds the pixel accepted i+1 pixels ago; win_q[ky*K+kx], ky=0 is the oldest row.
  logic [DATA_WIDTH-1:0] lb_q  [LB_LEN];
  logic [DATA_WIDTH-1:0] win_q [TAPS];
  logic [DATA_WIDTH-1:0] col_new [K];

  // New rightmost window column: the same image column from the K-1 rows above plus the new pixel.
  always_comb begin
    for (int j = 0; j < int'(K); j++) col_new[j] = '0;
    col_new[K-1] = pixel_i;
    for (int j = 1; j < int'(K); j++) col_new[K-1-j] = lb_q[j*IMG_W-1];
  end

  // Shift line buffer and window one pixel on every accepted pixel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(LB_LEN); i++) lb_q[i] <= '0;
      for (int i = 0; i < int'(TAPS); i++) win_q[i] <= '0;
    end else if (en_i) begin
      lb_q[0] <= pixel_i;
      for (int i = 1; i < int'(LB_LEN); i++) lb_q[i] <= lb_q[i-1];
      for (int ky = 0; ky < int'(K); ky++) begin
        for (int kx = 0; kx < int'(K) - 1; kx++) win_q[ky*K+kx] <= win_q[ky*K+kx+1];
        win_q[ky*K+K-1] <= col_new[ky];
      end
    end
  end

  // Flatten the window for the MAC array.
  always_comb begin
    win_o = '0;
    for (int i = 0; i < int'(TAPS); i++) win_o[i*DATA_WIDTH +: DATA_WIDTH] = win_q[i];
  end

endmodule

// File: rtl/conv_stream_core.sv
// Streaming valid-mode 2D convolution: one KxK MAC array shared across output channels.
module conv_stream_core
  import conv_pkg::*;
#(
  parameter int unsigned IMG_W        = 28,
  parameter int unsigned IMG_H        = 28,
  parameter int unsigned K            = 5,
  parameter int unsigned OUT_CH       = 6,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned WEIGHT_WIDTH = 8,
  parameter int unsigned OUT_WIDTH    = 32
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   cfg_we,
  input  logic [addr_w(OUT_CH*ch_stride(K))-1:0] cfg_addr,
  input  logic [WEIGHT_WIDTH-1:0]                cfg_wdata,
  input  logic                                   cfg_relu,
  input  logic                                   start,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [DATA_WIDTH-1:0]                  pixel_in,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [OUT_WIDTH-1:0]                   out_data,
  output logic [addr_w(OUT_CH)-1:0]              out_ch,
  output logic [addr_w(IMG_H)-1:0]               out_row,
  output logic [addr_w(IMG_W)-1:0]               out_col,
  output logic                                   busy,
  output logic                                   frame_done
);

  localparam int unsigned NUM_TAPS = num_taps(K);
  localparam int unsigned STRIDE   = ch_stride(K);
  localparam int unsigned NUM_W    = OUT_CH * STRIDE;
  localparam int unsigned AW       = addr_w(NUM_W);
  localparam int unsigned CH_W     = addr_w(OUT_CH);
  localparam int unsigned ROW_W    = addr_w(IMG_H);
  localparam int unsigned COL_W    = addr_w(IMG_W);
  localparam int unsigned PW       = WEIGHT_WIDTH + DATA_WIDTH + 1;

  state_e                   state_q, state_d;
  logic [COL_W-1:0]         col_q, col_d;
  logic [ROW_W-1:0]         row_q, row_d;
  logic [CH_W-1:0]          ch_q, ch_d;
  logic [ROW_W-1:0]         win_row_q, win_row_d;
  logic [COL_W-1:0]         win_col_q, win_col_d;
  logic                     last_q, last_d;
  logic                     relu_q, relu_d;
  logic                     out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0]     out_data_q, out_data_d;
  logic                     frame_done_q, frame_done_d;

  logic signed [WEIGHT_WIDTH-1:0] w_q [NUM_W];
  logic [NUM_TAPS*DATA_WIDTH-1:0] win;
  logic signed [OUT_WIDTH-1:0]    mac_c;
  logic                           accept;

  assign in_ready   = (state_q == ST_RUN);
  assign busy       = (state_q != ST_IDLE);
  assign accept     = in_ready && in_valid;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_ch     = ch_q;
  assign out_row    = win_row_q;
  assign out_col    = win_col_q;
  assign frame_done = frame_done_q;

  conv_line_window #(
    .IMG_W      (IMG_W),
    .K          (K),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_line_window (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (accept),
    .pixel_i (pixel_in),
    .win_o   (win)
  );

  // Weight/bias memory, writable only while idle; addresses past the last bias are dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_W); i++) w_q[i] <= '0;
    end else if (cfg_we && (state_q == ST_IDLE) && (32'(cfg_addr) < NUM_W)) begin
      w_q[cfg_addr] <= cfg_wdata;
    end
  end

  // Channel ch_q result: sign-extended bias plus full-width weight x zero-extended pixel products.
  always_comb begin
    int unsigned base;
    logic signed [PW-1:0]        prod;
    logic signed [OUT_WIDTH-1:0] acc;
    base = 32'(ch_q) * STRIDE;
    acc  = OUT_WIDTH'(w_q[AW'(base + NUM_TAPS)]);
    prod = '0;
    for (int t = 0; t < int'(NUM_TAPS); t++) begin
      prod = PW'(w_q[AW'(base + 32'(t))]) * PW'($signed({1'b0, win[t*DATA_WIDTH +: DATA_WIDTH]}));
      acc  = acc + OUT_WIDTH'(prod);
    end
    mac_c = (relu_q && acc[OUT_WIDTH-1]) ? '0 : acc;
  end

  // Next-state and datapath control.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    ch_d         = ch_q;
    win_row_d    = win_row_q;
    win_col_d    = win_col_q;
    last_d       = last_q;
    relu_d       = relu_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          col_d   = '0;
          row_d   = '0;
          ch_d    = '0;
          last_d  = 1'b0;
          relu_d  = cfg_relu;
        end
      end
      ST_RUN: begin
        if (accept) begin
          if (col_q == COL_W'(IMG_W - 1)) begin
            col_d = '0;
            row_d = row_q + ROW_W'(1);
          end else begin
            col_d = col_q + COL_W'(1);
          end
          if ((row_q >= ROW_W'(K - 1)) && (col_q >= COL_W'(K - 1))) begin
            state_d   = ST_EMIT;
            ch_d      = '0;
            win_row_d = row_q - ROW_W'(K - 1);
            win_col_d = col_q - COL_W'(K - 1);
            last_d    = (row_q == ROW_W'(IMG_H - 1)) && (col_q == COL_W'(IMG_W - 1));
          end
        end
      end
      ST_EMIT: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_data_d  = mac_c;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          if (ch_q == CH_W'(OUT_CH - 1)) begin
            ch_d = '0;
            if (last_q) begin
              state_d      = ST_IDLE;
              frame_done_d = 1'b1;
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            ch_d = ch_q + CH_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      ch_q         <= '0;
      win_row_q    <= '0;
      win_col_q    <= '0;
      last_q       <= 1'b0;
      relu_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      ch_q         <= ch_d;
      win_row_q    <= win_row_d;
      win_col_q    <= win_col_d;
      last_q       <= last_d;
      relu_q       <= relu_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_conv_stream_core.sv
// Directed self-checking bench for conv_stream_core (default 28x28, K=5, 6 channels).
module tb_conv_stream_core;

  localparam int IMG_W = 28;
  localparam int IMG_H = 28;
  localparam int KS    = 5;
  localparam int NCH   = 6;
  localparam int OW    = IMG_W - KS + 1;
  localparam int OH    = IMG_H - KS + 1;
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int NOUT  = OW * OH * NCH;
  localparam int NW    = NCH * (KS * KS + 1);

  logic        clk;
  logic        rst_n;
  logic        cfg_we;
  logic [7:0]  cfg_addr;
  logic [7:0]  cfg_wdata;
  logic        cfg_relu;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  pixel_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_ch;
  logic [4:0]  out_row;
  logic [4:0]  out_col;
  logic        busy;
  logic        frame_done;

  conv_stream_core dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .cfg_relu   (cfg_relu),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .pixel_in   (pixel_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ch     (out_ch),
    .out_row    (out_row),
    .out_col    (out_col),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int mode     = 0;
  bit relu_exp = 1'b0;

  int out_cnt = 0;
  int bad_cnt = 0;
  int done_cnt = 0;
  int exp_ch = 0;
  int exp_row = 0;
  int exp_col = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pixel image for each test mode.
  function automatic int pix_at(input int m, input int r, input int c);
    case (m)
      0:       return 1;
      1:       return (r * 7 + c * 3) % 256;
      default: return 255;
    endcase
  endfunction

  // Hand-derived expected result for window (r,c), channel ch.
  function automatic int model(input int ch, input int r, input int c);
    int v;
    case (mode)
      0: v = 25;
      1: begin
        case (ch)
          1:       v = 2 * pix_at(1, r + 1, c + 3);
          2:       v = -3;
          3:       v = -pix_at(1, r, c);
          default: v = 0;
        endcase
      end
      default: v = -816128;
    endcase
    if (relu_exp && v < 0) v = 0;
    return v;
  endfunction

  // Output monitor: compares each accepted result with the model and the expected raster order.
  always @(negedge clk) begin
    if (rst_n && start && !busy) begin
      out_cnt  <= 0;
      bad_cnt  <= 0;
      done_cnt <= 0;
      exp_ch   <= 0;
      exp_row  <= 0;
      exp_col  <= 0;
    end else begin
      if (out_valid && out_ready) begin
        out_cnt <= out_cnt + 1;
        if (int'($signed(out_data)) != model(exp_ch, exp_row, exp_col) || int'(out_ch) != exp_ch ||
            int'(out_row) != exp_row || int'(out_col) != exp_col)
          bad_cnt <= bad_cnt + 1;
        if (exp_ch == NCH - 1) begin
          exp_ch <= 0;
          if (exp_col == OW - 1) begin
            exp_col <= 0;
            exp_row <= exp_row + 1;
          end else begin
            exp_col <= exp_col + 1;
          end
        end else begin
          exp_ch <= exp_ch + 1;
        end
      end
      if (frame_done) done_cnt <= done_cnt + 1;
    end
  end

  task automatic cfg_write(input int addr, input int data);
    cfg_we    = 1'b1;
    cfg_addr  = 8'(addr);
    cfg_wdata = 8'(data);
    @(posedge clk); #1;
    cfg_we    = 1'b0;
  endtask

  task automatic start_frame(input bit relu);
    cfg_relu = relu;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  task automatic feed(input int m, input int npix);
    int waited;
    for (int i = 0; i < npix; i++) begin
      pixel_in = 8'(pix_at(m, i / IMG_W, i % IMG_W));
      in_valid = 1'b1;
      waited   = 0;
      while (!in_ready && waited < 2000) begin
        @(posedge clk); #1;
        waited++;
      end
      if (!in_ready) begin
        check("in_ready_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_cnt == 0 && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
    check("frame_done_timeout", int'(done_cnt > 0), 1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic wait_outputs(input int n);
    int t;
    t = 0;
    while (out_cnt < n && t < 20000) begin
      @(posedge clk); #1;
      t++;
    end
    check("out_cnt_reached", int'(out_cnt >= n), 1);
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_outputs"}, out_cnt, NOUT);
    check({tag, "_bad"}, bad_cnt, 0);
    check({tag, "_frame_done"}, done_cnt, 1);
    check({tag, "_idle"}, int'(busy), 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_in_ready"}, int'(in_ready), 0);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_frame_done"}, int'(frame_done), 0);
    check({tag, "_out_data"}, int'(out_data), 0);
    check({tag, "_out_ch"}, int'(out_ch), 0);
    check({tag, "_out_row"}, int'(out_row), 0);
    check({tag, "_out_col"}, int'(out_col), 0);
  endtask

  initial begin
    int saved;
    int unstable;
    int t;
    logic [31:0] h_data;
    logic [2:0]  h_ch;
    logic [4:0]  h_row;
    logic [4:0]  h_col;

    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; cfg_relu = 1'b0;
    start = 1'b0; in_valid = 1'b0; pixel_in = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Frame 1: unit weights, zero biases, unit pixels; illegal cfg writes and a stray start mid-frame.
    for (int ch = 0; ch < NCH; ch++)
      for (int tp = 0; tp < KS * KS; tp++) cfg_write(ch * (KS * KS + 1) + tp, 1);
    mode = 0; relu_exp = 1'b0;
    start_frame(1'b0);
    fork
      feed(0, NPIX);
      begin
        wait_outputs(50);
        t = 0;
        while (!in_ready && t < 200) begin @(posedge clk); #1; t++; end
        cfg_write(0, 7);
        t = 0;
        while (!out_valid && t < 200) begin @(posedge clk); #1; t++; end
        start = 1'b1;
        cfg_write(25, 7);
        start = 1'b0;
      end
    join
    wait_done();
    check_frame("f1");

    // Partial frame abandoned by reset.
    start_frame(1'b0);
    feed(0, 200);
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_zero_outputs("abort");
    rst_n = 1'b1;
    saved = out_cnt;
    repeat (5) @(posedge clk);
    #1;
    check("abort_no_outputs", out_cnt, saved);
    check("abort_stays_idle", int'(busy), 0);

    // Frame 2: weights cleared by reset except ch2 bias -3, ch1 tap (1,3)=2, ch3 tap (0,0)=-1.
    cfg_write(2 * 26 + 25, -3);
    cfg_write(1 * 26 + 1 * 5 + 3, 2);
    cfg_write(3 * 26, -1);
    mode = 1; relu_exp = 1'b0;
    start_frame(1'b0);
    feed(1, NPIX);
    wait_done();
    check_frame("f2_relu0");

    // Frame 3: same weights with ReLU.
    relu_exp = 1'b1;
    start_frame(1'b1);
    feed(1, NPIX);
    wait_done();
    check_frame("f3_relu1");

    // Frame 4: extreme negative weights/biases, saturated pixels, 10-cycle output stall.
    for (int a = 0; a < NW; a++) cfg_write(a, -128);
    cfg_write(255, 7);
    mode = 2; relu_exp = 1'b0;
    start_frame(1'b0);
    fork
      feed(2, NPIX);
      begin
        wait_outputs(300);
        t = 0;
        while (!out_valid && t < 200) begin @(posedge clk); #1; t++; end
        out_ready = 1'b0;
        h_data = out_data; h_ch = out_ch; h_row = out_row; h_col = out_col;
        saved = out_cnt;
        unstable = 0;
        repeat (10) begin
          @(posedge clk); #1;
          if (out_data !== h_data || out_ch !== h_ch || out_row !== h_row ||
              out_col !== h_col || out_valid !== 1'b1 || in_ready !== 1'b0)
            unstable++;
        end
        check("stall_stable", unstable, 0);
        check("stall_no_handshake", out_cnt, saved);
        check("stall_value", int'($signed(h_data)), -816128);
        out_ready = 1'b1;
      end
    join
    wait_done();
    check_frame("f4_neg");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/conv_stream_core.md
CONV_STREAM_CORE -- requirements
Module: conv_stream_core

Interface
REQ-001 SHALL have parameter IMG_W, default 28, input image width in pixels.
REQ-002 SHALL have parameter IMG_H, default 28, input image height in pixels.
REQ-003 SHALL have parameter K, default 5, square kernel size (K >= 2).
REQ-004 SHALL have parameter OUT_CH, default 6, number of output channels.
REQ-005 SHALL have parameters DATA_WIDTH 8 (unsigned pixel), WEIGHT_WIDTH 8 (signed weight/bias) and OUT_WIDTH 32 (signed result).
REQ-006 SHALL have ports:
- clk, input, 1: the single clock.
- rst_n, input, 1: reset, synchronous and active-low.
- cfg_we, input, 1: write strobe for a weight or bias.
- cfg_addr, input, clog2(OUT_CH*(K*K+1)): weight/bias address.
- cfg_wdata, input, WEIGHT_WIDTH: signed weight or bias value.
- cfg_relu, input, 1: ReLU enable, sampled on start.
- start, input, 1: begin a frame.
- in_valid / in_ready, input / output, 1: pixel handshake.
- pixel_in, input, DATA_WIDTH: raster-order pixel.
- out_valid / out_ready, output / input, 1: result handshake.
- out_data, output, OUT_WIDTH: signed result.
- out_ch, output, clog2(OUT_CH): channel of out_data.
- out_row / out_col, output, clog2(IMG_H) / clog2(IMG_W): output coordinate.
- busy, output, 1: frame in progress.
- frame_done, output, 1: one-cycle pulse at end of frame.

Function
REQ-007 SHALL implement states IDLE, RUN, EMIT, with transitions IDLE->RUN on start, RUN->EMIT on a window-completing pixel, EMIT->RUN after the last-channel handshake, and EMIT->IDLE after the final window's last channel.
REQ-008 SHALL store weights/biases at address ch*(K*K+1)+ky*K+kx, with the bias at ch*(K*K+1)+K*K; writes SHALL take effect only in IDLE, and out-of-range addresses SHALL be ignored.
REQ-009 SHALL assert in_ready only in RUN; a pixel is consumed only when in_valid&&in_ready.
REQ-010 SHALL track the column/row of each accepted pixel, wrapping the column at IMG_W-1 and incrementing the row.
REQ-011 SHALL form a window only when row>=K-1 and col>=K-1 (valid convolution), giving (IMG_H-K+1)x(IMG_W-K+1) windows.
REQ-012 SHALL compute out_data = bias[c] + sum(w[c][ky][kx] * {1'b0,pixel}) for each window, with pixels zero-extended to signed, products full-width, and the bias sign-extended and unshifted.
REQ-013 SHALL replace negative results with 0 when the latched cfg_relu is 1.
REQ-014 SHALL time-multiplex one K*K MAC array across channels and emit channels 0..OUT_CH-1 in order, one per out handshake.
REQ-015 SHALL meet this latency: a window-completing pixel accepted in cycle T gives out_valid=1 with out_ch=0 in cycle T+2 at the earliest.
REQ-016 SHALL place channel c+1 on the output no earlier than the cycle after channel c's handshake.
REQ-017 SHALL hold out_data, out_ch, out_row and out_col stable while out_valid && !out_ready.
REQ-018 SHALL set out_row/out_col to the window's top-left output coordinate (0..IMG_H-K, 0..IMG_W-K).
REQ-019 SHALL pulse frame_done for one cycle after the last channel of the last window is accepted, then enter IDLE.
REQ-020 SHALL ignore start while busy; busy SHALL equal (state != IDLE).

Reset
REQ-021 SHALL, on rst_n=0 at a clk edge, enter IDLE, clear the counters, line buffers and window, set every weight/bias to 0, set the latched relu to 0, and drive in_ready, out_valid, busy, frame_done=0 and out_data, out_ch, out_row, out_col=0.
REQ-022 SHALL abandon any frame in progress on reset mid-frame, with no further outputs until a new start.

Structure
REQ-023 SHALL take the state encoding, NUM_TAPS=K*K, the per-channel stride K*K+1 and the address width function from shared package conv_pkg.
REQ-024 SHALL place the K-1 line buffers and the KxK window shift register in sub-module conv_line_window (parameters IMG_W, K, DATA_WIDTH; enable = pixel accepted).

Verification
REQ-025 SHALL cover: all weights 1, biases 0, all pixels 1 -> 576 windows x 6 = 3456 outputs, each 25, and exactly one frame_done.
REQ-026 SHALL cover: weights 0, ch2 bias -3, cfg_relu=0 -> ch2 out_data=-3; cfg_relu=1 -> 0.
REQ-027 SHALL cover: pixels 255, all weights -128, biases -128 -> every out_data = -816128, with no overflow.
REQ-028 SHALL cover: out_ready held low 10 cycles mid-frame -> output fields stable, in_ready=0, and no output lost or duplicated.
REQ-029 SHALL cover: cfg_we during RUN writing 7 -> ignored, results unchanged; rst_n low mid-frame -> all outputs 0, and the next frame is correct.
